// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 receiver and anything that builds frames.
package ps2_pkg;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

  // Parity bit that makes data plus parity contain an odd number of ones.
  function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_cond.sv
// Conditions one asynchronous PS/2 line: synchroniser, glitch filter, falling-edge strobe.
module ps2_line_cond #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic line_in,
  output logic sync_out,
  output logic filt_out,
  output logic fall
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   filt_q, filt_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  // Shift the raw line in and count consecutive samples that disagree with the filtered level.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and no latch is inferred.
    sync_d = {sync_q[SYNC_STAGES-2:0], line_in};
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[SYNC_STAGES-1] != filt_q) begin
      if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        filt_d = sync_q[SYNC_STAGES-1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Register the synchroniser chain, the filtered level and the agreement counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the chain presets to 1 (the idle line level) so releasing reset never fakes a falling edge.
      sync_q <= '1;
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      sync_q <= sync_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign filt_out = filt_q;
  // Asserted on the cycle the filtered level is about to go 1 -> 0.
  assign fall     = filt_q & ~filt_d;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: start, 8 data bits LSB first, odd parity, stop; one-entry valid/ready output.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 2000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC);

  logic clk_fall;
  logic dat_sync;
  logic unused_clk_sync, unused_dat_filt, unused_dat_fall;

  rx_state_e                state_q, state_d;
  logic [2:0]               bit_cnt_q, bit_cnt_d;
  logic [PS2_DATA_BITS-1:0] shift_q, shift_d;
  logic                     par_q, par_d;
  logic [TMO_W-1:0]         tmo_q, tmo_d;
  logic [7:0]               rx_data_q, rx_data_d;
  logic                     rx_valid_q, rx_valid_d;
  logic                     parity_err_q, parity_err_d;
  logic                     frame_err_q, frame_err_d;
  logic                     overrun_q, overrun_d;
  logic                     timeout;
  logic                     load;

  ps2_line_cond #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_clk_cond (
    .clk      (clk),
    .reset_n  (reset_n),
    .line_in  (ps2_clk),
    .sync_out (unused_clk_sync),
    .filt_out (),
    .fall     (clk_fall)
  );

  // Data is stable around the clock edge, so it only needs synchronising.
  ps2_line_cond #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(1)) u_dat_cond (
    .clk      (clk),
    .reset_n  (reset_n),
    .line_in  (ps2_dat),
    .sync_out (dat_sync),
    .filt_out (unused_dat_filt),
    .fall     (unused_dat_fall)
  );

  // A partial frame is abandoned once the clock has been quiet for TIMEOUT_CYC cycles.
  assign timeout = (state_q != IDLE) && !clk_fall && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: advance one frame field per filtered falling edge.
  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = IDLE;
    end else if (clk_fall) begin
      unique case (state_q)
        IDLE:    if (!dat_sync) state_d = DATA;
        DATA:    if (bit_cnt_q == 3'(PS2_DATA_BITS - 1)) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output/datapath logic: shift bits in, judge the frame at the stop bit, run the handshake.
  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    load         = 1'b0;

    if (state_q == IDLE || clk_fall || timeout) tmo_d = '0;
    else                                        tmo_d = tmo_q + 1'b1;

    if (clk_fall) begin
      unique case (state_q)
        IDLE:   bit_cnt_d = '0;
        DATA: begin
          shift_d[bit_cnt_q] = dat_sync;
          bit_cnt_d          = bit_cnt_q + 3'd1;
        end
        PARITY: par_d = dat_sync;
        STOP: begin
          if (!dat_sync)                          frame_err_d  = 1'b1;
          else if (par_q != odd_parity(shift_q))  parity_err_d = 1'b1;
          else if (rx_valid_q && !rx_ready)       overrun_d    = 1'b1;
          else                                    load         = 1'b1;
        end
        default: ;
      endcase
    end

    if (timeout) frame_err_d = 1'b1;

    // A load in the same cycle as an accept simply replaces the byte and keeps valid high.
    if (load) begin
      rx_data_d  = shift_q;
      rx_valid_d = 1'b1;
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      tmo_q        <= '0;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      tmo_q        <= tmo_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: frame table plus directed handshake, timeout, reset and glitch sequences.
module tb_ps2_rx;
  import ps2_pkg::*;

  localparam int SYNC_STAGES = 2;
  localparam int FILTER_LEN  = 4;
  localparam int TIMEOUT_CYC = 2000;
  localparam int HALF        = 20;   // system cycles per PS/2 clock phase

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ps2_clk;
  logic       ps2_dat;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  always #5 clk = ~clk;

  ps2_rx #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  typedef struct {
    logic [7:0] data;
    logic       flip_par;
    logic       stop;
    int         exp_deliv;
    int         exp_perr;
    int         exp_ferr;
  } vec_t;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- output monitor (samples on the falling system-clock edge) ----------------
  logic [7:0] got_mem [256];
  int         got_wr    = 0;
  int         perr_cnt  = 0;
  int         ferr_cnt  = 0;
  int         ovr_cnt   = 0;
  int         excl_viol = 0;
  int         stab_viol = 0;
  int         busy_hi   = 0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (reset_n) begin
      if (rx_valid && rx_ready) begin
        got_mem[got_wr % 256] = rx_data;
        got_wr++;
      end
      if (parity_err) perr_cnt++;
      if (frame_err)  ferr_cnt++;
      if (overrun)    ovr_cnt++;
      if (32'(parity_err) + 32'(frame_err) + 32'(overrun) > 1) excl_viol++;
      if (prev_hold && rx_valid && (rx_data !== prev_data)) stab_viol++;
      if (busy) busy_hi++;
      prev_hold = rx_valid && !rx_ready;
      prev_data = rx_data;
    end else begin
      prev_hold = 1'b0;
    end
  end

  // ---------------- frame construction, pusher and reference model ----------------
  function automatic logic [10:0] make_frame(input logic [7:0] d, input logic flip_par,
                                             input logic stop);
    return {stop, odd_parity(d) ^ flip_par, d, 1'b0};
  endfunction

  // Expected outcome of one whole frame, straight from the frame rules.
  function automatic vec_t ref_outcome(input logic [7:0] d, input logic flip_par,
                                       input logic stop);
    vec_t       v;
    logic [10:0] f;
    f           = make_frame(d, flip_par, stop);
    v.data      = d;
    v.flip_par  = flip_par;
    v.stop      = stop;
    v.exp_deliv = 0;
    v.exp_perr  = 0;
    v.exp_ferr  = 0;
    if (f[10] == 1'b0)                      v.exp_ferr  = 1;
    else if ($countones(f[9:1]) % 2 == 0)   v.exp_perr  = 1;
    else                                    v.exp_deliv = 1;
    return v;
  endfunction

  // Device-side pusher: data changes mid-high, then a low phase, for the first n bits.
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ps2_dat = bits[i];
      repeat (HALF / 2) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (HALF / 2) @(negedge clk);
    end
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1 rx_ready = r;
  endtask

  // Push one frame with rx_ready high and compare what came out against the vector.
  task automatic apply_vec(input vec_t v, input string tag);
    int w0, p0, f0;
    w0 = got_wr;
    p0 = perr_cnt;
    f0 = ferr_cnt;
    send_bits(make_frame(v.data, v.flip_par, v.stop), PS2_FRAME_BITS);
    repeat (5) @(negedge clk);
    check({tag, " deliv"}, got_wr - w0, v.exp_deliv);
    check({tag, " perr"},  perr_cnt - p0, v.exp_perr);
    check({tag, " ferr"},  ferr_cnt - f0, v.exp_ferr);
    if (v.exp_deliv == 1 && got_wr > w0) check({tag, " data"}, 32'(got_mem[w0 % 256]), 32'(v.data));
    check({tag, " busy"}, 32'(busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    vec_t vecs[$];
    vec_t v;
    int   w0, o0, f0, b0, e0, cyc;

    // Table: ordered bytes, directed bad frames, then randomised frames judged by the model.
    for (int i = 0; i < 16; i++) begin
      v = '{data: 8'(i), flip_par: 1'b0, stop: 1'b1, exp_deliv: 1, exp_perr: 0, exp_ferr: 0};
      vecs.push_back(v);
    end
    v = '{data: 8'hA5, flip_par: 1'b1, stop: 1'b1, exp_deliv: 0, exp_perr: 1, exp_ferr: 0};
    vecs.push_back(v);
    v = '{data: 8'h3C, flip_par: 1'b0, stop: 1'b0, exp_deliv: 0, exp_perr: 0, exp_ferr: 1};
    vecs.push_back(v);
    for (int i = 0; i < 24; i++) begin
      vecs.push_back(ref_outcome(8'($urandom), ($urandom % 4) == 0, ($urandom % 4) != 0));
    end

    // Reset state, checked before any clock edge can have helped.
    reset_n  = 1'b0;
    ps2_clk  = 1'b1;
    ps2_dat  = 1'b1;
    rx_ready = 1'b0;
    #3;
    check("reset rx_data",  32'(rx_data), 0);
    check("reset rx_valid", 32'(rx_valid), 0);
    check("reset errs",     32'({parity_err, frame_err, overrun}), 0);
    check("reset busy",     32'(busy), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    set_ready(1'b1);
    repeat (5) @(negedge clk);

    foreach (vecs[i]) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Overrun: hold 0x12 unconsumed, 0x34 must be dropped with an overrun pulse.
    set_ready(1'b0);
    w0 = got_wr;
    o0 = ovr_cnt;
    send_bits(make_frame(8'h12, 1'b0, 1'b1), PS2_FRAME_BITS);
    repeat (5) @(negedge clk);
    check("hold valid", 32'(rx_valid), 1);
    check("hold data",  32'(rx_data), 32'h12);
    send_bits(make_frame(8'h34, 1'b0, 1'b1), PS2_FRAME_BITS);
    repeat (5) @(negedge clk);
    check("overrun pulse", ovr_cnt - o0, 1);
    check("overrun data",  32'(rx_data), 32'h12);
    check("overrun valid", 32'(rx_valid), 1);
    set_ready(1'b1);
    repeat (3) @(negedge clk);
    check("accept count", got_wr - w0, 1);
    if (got_wr > w0) check("accept data", 32'(got_mem[w0 % 256]), 32'h12);
    check("accept clears", 32'(rx_valid), 0);

    // Timeout: clock parks high after 4 data bits.
    f0 = ferr_cnt;
    send_bits(make_frame(8'hC3, 1'b0, 1'b1), 5);
    check("partial busy", 32'(busy), 1);
    cyc = 0;
    while (ferr_cnt == f0 && cyc < TIMEOUT_CYC + 200) begin
      @(negedge clk);
      cyc++;
    end
    check("timeout ferr", ferr_cnt - f0, 1);
    check("timeout window", 32'(cyc >= TIMEOUT_CYC - 60 && cyc <= TIMEOUT_CYC), 1);
    @(negedge clk);
    check("timeout busy", 32'(busy), 0);
    apply_vec(ref_outcome(8'h55, 1'b0, 1'b1), "after timeout");

    // Asynchronous reset mid-frame while a byte is held.
    set_ready(1'b0);
    send_bits(make_frame(8'h99, 1'b0, 1'b1), PS2_FRAME_BITS);
    send_bits(make_frame(8'h77, 1'b0, 1'b1), 6);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async rst valid", 32'(rx_valid), 0);
    check("async rst data",  32'(rx_data), 0);
    check("async rst busy",  32'(busy), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    set_ready(1'b1);
    apply_vec(ref_outcome(8'h81, 1'b0, 1'b1), "after reset");

    // Short low glitches on ps2_clk while idle with dat low must be ignored.
    for (int len = 1; len < FILTER_LEN; len += FILTER_LEN - 2) begin
      ps2_dat = 1'b0;
      b0 = busy_hi;
      e0 = perr_cnt + ferr_cnt + ovr_cnt;
      @(posedge clk);
      #1 ps2_clk = 1'b0;
      repeat (len) @(posedge clk);
      #1 ps2_clk = 1'b1;
      repeat (20) @(negedge clk);
      check($sformatf("glitch%0d busy", len), busy_hi - b0, 0);
      check($sformatf("glitch%0d errs", len), perr_cnt + ferr_cnt + ovr_cnt - e0, 0);
      ps2_dat = 1'b1;
      repeat (5) @(negedge clk);
    end

    check("error exclusivity", excl_viol, 0);
    check("held data stable",  stab_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
